// File: rtl/uart_host_tx.sv
// rtl/uart_host_tx.sv - UART transmitter: start, LSB-first data, optional parity, stop.
// Define UART_HOST_TX_BUF_EN to add a one-entry holding buffer for back-to-back frames.
module uart_host_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    localparam int CW = $clog2(PRESCALE);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  bit_end;
    logic                  parity_bit;

`ifdef UART_HOST_TX_BUF_EN
    logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;
    logic                  buf_par_en_q, buf_par_en_d;
    logic                  buf_par_typ_q, buf_par_typ_d;
    logic                  buf_full_q, buf_full_d;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        data_d     = data_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        tx_d       = tx_q;
        bit_end    = (cnt_q == CNT_LAST);
        cnt_d      = (state_q == S_IDLE || bit_end) ? '0 : cnt_q + 1'b1;
        parity_bit = (^data_q) ^ par_typ_q;
`ifdef UART_HOST_TX_BUF_EN
        buf_data_d    = buf_data_q;
        buf_par_en_d  = buf_par_en_q;
        buf_par_typ_d = buf_par_typ_q;
        buf_full_d    = buf_full_q;
`endif

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (DATA_VALID) begin
                    data_d    = P_DATA;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    state_d   = S_START;
                    tx_d      = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                    tx_d    = data_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        if (par_en_q) begin
                            state_d = S_PARITY;
                            tx_d    = parity_bit;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                        tx_d  = data_q[idx_q + 1'b1];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
`ifdef UART_HOST_TX_BUF_EN
                    // Chain straight into the next start bit so no idle cycle appears.
                    if (buf_full_q) begin
                        data_d     = buf_data_q;
                        par_en_d   = buf_par_en_q;
                        par_typ_d  = buf_par_typ_q;
                        buf_full_d = 1'b0;
                        state_d    = S_START;
                        tx_d       = 1'b0;
                    end else if (DATA_VALID) begin
                        data_d    = P_DATA;
                        par_en_d  = PAR_EN;
                        par_typ_d = PAR_TYP;
                        state_d   = S_START;
                        tx_d      = 1'b0;
                    end
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

`ifdef UART_HOST_TX_BUF_EN
        if (state_q != S_IDLE && !(state_q == S_STOP && bit_end) && !buf_full_q && DATA_VALID) begin
            buf_data_d    = P_DATA;
            buf_par_en_d  = PAR_EN;
            buf_par_typ_d = PAR_TYP;
            buf_full_d    = 1'b1;
        end
        busy_d = (state_d != S_IDLE) && buf_full_d;
`else
        busy_d = (state_d != S_IDLE);
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_HOST_TX_BUF_EN
            buf_data_q    <= '0;
            buf_par_en_q  <= 1'b0;
            buf_par_typ_q <= 1'b0;
            buf_full_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
`ifdef UART_HOST_TX_BUF_EN
            buf_data_q    <= buf_data_d;
            buf_par_en_q  <= buf_par_en_d;
            buf_par_typ_q <= buf_par_typ_d;
            buf_full_q    <= buf_full_d;
`endif
        end
    end

    assign TX_OUT = tx_q;
    assign BUSY   = busy_q;

endmodule

// File: tb/tb_uart_host_tx.sv
// tb/tb_uart_host_tx.sv - self-checking bench for uart_host_tx against a frame-level model.
module tb_uart_host_tx;

    localparam int P = 32;
    localparam int N = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [N-1:0] P_DATA = '0;
    logic         DATA_VALID = 1'b0;
    logic         PAR_EN = 1'b0;
    logic         PAR_TYP = 1'b0;
    logic         TX_OUT;
    logic         BUSY;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    uart_host_tx #(.DATA_WIDTH(N), .PRESCALE(P)) dut (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .TX_OUT(TX_OUT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // Frame model: a frame is a list of line levels, each held P cycles.
    logic [11:0] m_bits = '1;
    int          m_len = 0;
    int          m_pos = 0;
    bit          m_active = 0;
    bit          m_bufv = 0;
    logic [N-1:0] m_bd = '0;
    bit          m_bpe = 0, m_bpt = 0;
    logic        exp_tx = 1'b1;
    logic        exp_busy = 1'b0;

    task automatic m_start(input logic [N-1:0] d, input bit pe, input bit pt);
        int ones;
        ones = $countones(d);
        m_bits = '1;
        m_bits[0] = 1'b0;
        for (int i = 0; i < N; i++) m_bits[1+i] = d[i];
        if (pe) m_bits[N+1] = pt ? (ones % 2 == 0) : (ones % 2 == 1);
        m_len = pe ? N + 3 : N + 2;
        m_pos = 0;
        m_active = 1;
    endtask

    always @(posedge CLK) begin
        bit was_busy;
        bit ended;
        bit from_buf;
        was_busy = exp_busy;
        ended = 0;
        from_buf = 0;
        if (RST) begin
            m_active = 0;
            m_bufv = 0;
        end else begin
            if (m_active) begin
                m_pos++;
                if (m_pos == m_len * P) begin
                    m_active = 0;
                    ended = 1;
                end
            end
`ifdef UART_HOST_TX_BUF_EN
            if (ended && m_bufv) begin
                m_start(m_bd, m_bpe, m_bpt);
                m_bufv = 0;
                from_buf = 1;
            end
`endif
            if (!from_buf && DATA_VALID && !was_busy) begin
                if (!m_active) begin
                    m_start(P_DATA, PAR_EN, PAR_TYP);
                end
`ifdef UART_HOST_TX_BUF_EN
                else if (!m_bufv) begin
                    m_bd = P_DATA; m_bpe = PAR_EN; m_bpt = PAR_TYP; m_bufv = 1;
                end
`endif
            end
        end
        exp_tx = m_active ? m_bits[m_pos / P] : 1'b1;
`ifdef UART_HOST_TX_BUF_EN
        exp_busy = m_active && m_bufv;
`else
        exp_busy = m_active;
`endif
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            checks++;
            if (TX_OUT !== exp_tx || BUSY !== exp_busy) begin
                errors++;
                if (errors < 20)
                    $display("FAIL cycle_cmp t=%0t tx=%b busy=%b expected tx=%b busy=%b",
                             $time, TX_OUT, BUSY, exp_tx, exp_busy);
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge CLK);
        while ((m_active || m_bufv) && n < 4000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 4000) check("idle_timeout", 1, 0);
    endtask

    task automatic frame_check(input string nm, input logic [N-1:0] d, input bit pe, input bit pt,
                               input logic [10:0] exp_bits, input int nbits, input bit inject);
        int busy_cnt;
        busy_cnt = 0;
        wait_idle();
        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; DATA_VALID = 1'b1;
        for (int c = 0; c < nbits * P + 4; c++) begin
            @(negedge CLK);
            if (c == 0) begin
                DATA_VALID = 1'b0;
                P_DATA = N'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
            end
            if (inject && c == 100) begin P_DATA = 8'hFF; DATA_VALID = 1'b1; end
            if (inject && c == 101) DATA_VALID = 1'b0;
            if (c % P == P / 2 && c / P < nbits)
                check($sformatf("%s_bit%0d", nm, c / P), int'(TX_OUT), int'(exp_bits[c / P]));
            if (BUSY) busy_cnt++;
        end
`ifdef UART_HOST_TX_BUF_EN
        check({nm, "_busy_cycles"}, busy_cnt, 0);
`else
        check({nm, "_busy_cycles"}, busy_cnt, nbits * P);
`endif
    endtask

    initial begin
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        chk_en = 1;
        check("reset_tx", int'(TX_OUT), 1);
        check("reset_busy", int'(BUSY), 0);
        RST = 1'b0;

        frame_check("f5a", 8'h5A, 0, 0, 11'h2B4, 10, 0);
        frame_check("f07_even", 8'h07, 1, 0, 11'h60E, 11, 0);
        frame_check("f07_odd", 8'h07, 1, 1, 11'h40E, 11, 0);
`ifndef UART_HOST_TX_BUF_EN
        frame_check("f00_inject", 8'h00, 0, 0, 11'h200, 10, 1);
`endif

        // Abort mid data bit 3, then a clean frame.
        wait_idle();
        P_DATA = 8'hA5; PAR_EN = 0; DATA_VALID = 1'b1;
        for (int c = 0; c < 150; c++) begin
            @(negedge CLK);
            if (c == 0) DATA_VALID = 1'b0;
            if (c == 140) RST = 1'b1;
            if (c == 141) begin
                RST = 1'b0;
                check("abort_tx", int'(TX_OUT), 1);
                check("abort_busy", int'(BUSY), 0);
            end
        end
        frame_check("f3c", 8'h3C, 0, 0, 11'h278, 10, 0);

        // DATA_VALID together with RST is ignored.
        wait_idle();
        RST = 1'b1; DATA_VALID = 1'b1; P_DATA = 8'h81;
        @(negedge CLK);
        RST = 1'b0; DATA_VALID = 1'b0;
        check("rst_dv_busy", int'(BUSY), 0);
        @(negedge CLK);
        check("rst_dv_tx", int'(TX_OUT), 1);

`ifdef UART_HOST_TX_BUF_EN
        wait_idle();
        P_DATA = 8'h58; PAR_EN = 0; DATA_VALID = 1'b1;
        for (int c = 0; c < 330; c++) begin
            @(negedge CLK);
            DATA_VALID = 1'b0;
            if (c == 50) begin P_DATA = 8'h01; DATA_VALID = 1'b1; end
            if (c == 100) begin
                check("buf_full_busy", int'(BUSY), 1);
                P_DATA = 8'hAA; DATA_VALID = 1'b1;
            end
            if (c == 319) check("buf_stop_tx", int'(TX_OUT), 1);
            if (c == 320) check("buf_b2b_start", int'(TX_OUT), 0);
        end
`endif

        for (int c = 0; c < 12000; c++) begin
            @(negedge CLK);
            DATA_VALID = ($urandom_range(0, 39) == 0);
            P_DATA = N'($urandom);
            PAR_EN = 1'($urandom);
            PAR_TYP = 1'($urandom);
            RST = ($urandom_range(0, 2999) == 0);
        end
        DATA_VALID = 1'b0; RST = 1'b0;
        wait_idle();
        repeat (4) @(negedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_host_tx.md
UART_HOST_TX -- requirements
Module: uart_host_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, payload bits per frame.
REQ-002 Parameter PRESCALE, default 32, CLK cycles per serial bit; legal values 2..255.
REQ-003 CLK  input  1  Single clock; all state changes on its rising edge.
REQ-004 RST  input  1  Synchronous, active-high reset, sampled on rising CLK.
REQ-005 P_DATA  input  DATA_WIDTH  Parallel byte to transmit, LSB sent first.
REQ-006 DATA_VALID  input  1  P_DATA, PAR_EN and PAR_TYP are valid this cycle.
REQ-007 PAR_EN  input  1  1 = append parity bit.
REQ-008 PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-009 TX_OUT  output  1  Serial line, idle high, registered.
REQ-010 BUSY  output  1  High = new DATA_VALID is not accepted; registered.

Function
REQ-011 The block SHALL accept a byte on a rising edge where DATA_VALID=1 and BUSY=0, latching P_DATA, PAR_EN and PAR_TYP together; later input changes SHALL NOT affect the frame.
REQ-012 The block SHALL implement states IDLE, START, DATA, PARITY, STOP: IDLE->START on accept; START->DATA after PRESCALE cycles; DATA->PARITY after DATA_WIDTH bits if latched PAR_EN=1, else DATA->STOP; PARITY->STOP after PRESCALE cycles; STOP->IDLE after PRESCALE cycles.
REQ-013 TX_OUT SHALL be 0 for PRESCALE cycles starting the cycle after accept (start bit), then data bits LSB first, each held exactly PRESCALE cycles.
REQ-014 Parity bit SHALL be XOR of latched data for even (PAR_TYP=0) and XNOR for odd (PAR_TYP=1), held PRESCALE cycles.
REQ-015 Stop bit SHALL be 1 for PRESCALE cycles; TX_OUT SHALL remain 1 in IDLE.
REQ-016 Frame length SHALL be exactly (DATA_WIDTH+2)*PRESCALE cycles without parity and (DATA_WIDTH+3)*PRESCALE with parity.
REQ-017 BUSY SHALL rise on the same edge TX_OUT drops for the start bit and fall on the edge the stop bit completes.
REQ-018 DATA_VALID while BUSY=1 SHALL be ignored (no buffering, no corruption of current frame), except as defined in REQ-024.
REQ-019 Prescale counter SHALL count 0..PRESCALE-1 and wrap; bit index SHALL count 0..DATA_WIDTH-1 and clear on leaving DATA.

Reset
REQ-020 On RST=1 at a rising edge, state SHALL go to IDLE, TX_OUT=1, BUSY=0, counters and latched data cleared.
REQ-021 RST during any frame SHALL abort it immediately; TX_OUT SHALL be 1 from the next cycle, no partial bits resumed.
REQ-022 DATA_VALID in the same cycle as RST=1 SHALL be ignored.

Configuration
REQ-023 Macro UART_HOST_TX_BUF_EN SHALL compile in a one-entry holding buffer; without it behaviour is exactly REQ-011..REQ-019.
REQ-024 With UART_HOST_TX_BUF_EN defined: a byte with DATA_VALID=1 during a frame SHALL be stored if the buffer is empty; BUSY SHALL be high only while a frame is in progress and the buffer is full; the buffered byte SHALL start its start bit the cycle after the current stop bit ends (no idle cycle); DATA_VALID in IDLE with empty buffer SHALL behave as REQ-011; RST SHALL clear the buffer.

Verification
REQ-025 RST pulse mid-data-bit 3 of a frame -> TX_OUT=1, BUSY=0 next cycle; subsequent 0x3C frame transmits intact.
REQ-026 PAR_EN=0, P_DATA=0x5A accepted -> TX_OUT sequence 0,0,1,0,1,1,0,1,0,1 per bit, each 32 cycles; BUSY high 320 cycles.
REQ-027 PAR_EN=1, PAR_TYP=0, P_DATA=0x07 -> parity bit 1; PAR_TYP=1, P_DATA=0x07 -> parity bit 0; frame 352 cycles.
REQ-028 DATA_VALID with P_DATA=0xFF asserted mid-frame of 0x00 (no buffer build) -> 0xFF never transmitted; 0x00 frame unchanged.
REQ-029 With UART_HOST_TX_BUF_EN: send 0x58 then 0x01 during first frame -> two back-to-back frames, start bit of 0x01 immediately follows stop bit of 0x58; third DATA_VALID while buffer full sees BUSY=1 and is dropped.
